// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode handshake and execute redirect.
// The master side is the fetch unit; the slave side is its environment (memory, decode, execute).
interface fetch_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              out_misaligned;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, out_misaligned,
        input  imem_instr, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, out_misaligned,
        output imem_instr, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses a synchronous-read memory, and pairs each
// returned word with its PC over a valid/ready handshake. Redirects from execute take priority.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 12
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     bus,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
);
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] pc_q, pc_d;
    logic        v_q, v_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        advance;

    assign advance = !v_q || bus.out_ready;

    // On a stall the held PC is re-addressed so the registered memory output repeats the same word.
    always_comb begin
        fpc_d         = fpc_q;
        pc_d          = pc_q;
        v_d           = v_q;
        bus.imem_addr = pc_q[ADDR_W+1:2];
        if (bus.redirect_valid) begin
            pc_d          = bus.redirect_pc;
            fpc_d         = bus.redirect_pc + 32'd4;
            v_d           = 1'b1;
            bus.imem_addr = bus.redirect_pc[ADDR_W+1:2];
        end else if (advance) begin
            pc_d          = fpc_q;
            fpc_d         = fpc_q + 32'd4;
            v_d           = 1'b1;
            bus.imem_addr = fpc_q[ADDR_W+1:2];
        end
    end

    // A handshake coinciding with a redirect is discarded, so it is not counted.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (v_q && bus.out_ready && !bus.redirect_valid) fetch_count_d = fetch_count_q + 32'd1;
        if (v_q && !bus.out_ready)                      stall_count_d = stall_count_q + 32'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            pc_q          <= RESET_PC;
            v_q           <= 1'b0;
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fpc_q         <= fpc_d;
            pc_q          <= pc_d;
            v_q           <= v_d;
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.out_valid      = v_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_instr      = bus.imem_instr;
    assign bus.out_misaligned = v_q && (pc_q[1:0] != 2'b00);
    assign fetch_count_o      = fetch_count_q;
    assign stall_count_o      = stall_count_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage in front of the 4096-word synchronous-read instruction memory. Owns the program counter, drives the memory word address and pairs each returned 32-bit word with its PC. Presents instructions to decode over a valid/ready handshake and accepts PC redirects from execute. Stalls replay the held address so the memory's registered output stays stable with no enable pin.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0
- ADDR_W, 12, memory word-address width; memory depth 2^ADDR_W words
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- imem_addr  out  ADDR_W  word address to instruction memory (pc[ADDR_W+1:2]), combinational
- imem_instr  in  32  memory read data, valid one cycle after the address it was fetched with
- out_valid  out  1  out_instr/out_pc hold a live instruction
- out_ready  in  1  decode accepts this cycle
- out_instr  out  32  instruction (passthrough of imem_instr)
- out_pc  out  32  byte PC of out_instr
- out_misaligned  out  1  out_pc[1:0] != 0 (came from a misaligned redirect)
- redirect_valid  in  1  execute requests a PC change (branch/jump/trap)
- redirect_pc  in  32  target byte address
- fetch_count  out  32  instructions accepted by decode (out_valid && out_ready)
- stall_count  out  32  cycles with out_valid && !out_ready

## Operation
- State: fpc (next PC to issue), pc_q (PC whose data is at imem_instr), v_q (that data is live), two 32-bit counters.
- advance = !v_q || out_ready.
- imem_addr selection, priority order: redirect_valid -> redirect_pc[ADDR_W+1:2]; advance -> fpc[ADDR_W+1:2]; else (stall) -> pc_q[ADDR_W+1:2] (replay, so the next memory word equals the held word).
- Clock edge, same priority:
  - redirect: pc_q <= redirect_pc; fpc <= redirect_pc + 4; v_q <= 1. Any held or in-flight instruction is discarded, including one being handed over the same cycle (not counted).
  - advance: pc_q <= fpc; fpc <= fpc + 4; v_q <= 1.
  - stall: all state holds.
- out_valid = v_q; out_pc = pc_q; out_instr = imem_instr; out_misaligned = v_q && (pc_q[1:0] != 0).
- Misaligned redirect: fetch uses the truncated word address; fpc advances by 4 from the unaligned value; out_misaligned remains set until the next aligned redirect. Decode is responsible for trapping.
- PC arithmetic is 32-bit modulo 2^32. The word address wraps modulo 2^ADDR_W: pc 0x0000_3FFC -> next imem_addr 0, out_pc 0x0000_4000.
- Counters are 32-bit, increment per the definitions above, and wrap silently. The fetch_count increment is suppressed on redirect cycles.

## Timing
- Reset values (asynchronous): fpc = RESET_PC, pc_q = RESET_PC, v_q = 0, out_valid = 0, out_misaligned = 0, fetch_count = 0, stall_count = 0. imem_addr = RESET_PC word while reset is held.
- First out_valid: the first rising edge after reset deasserts sets v_q. out_instr = mem[RESET_PC>>2] from that edge onward.
- Throughput: one instruction per cycle while out_ready = 1; no bubbles.
- Redirect latency: redirect_valid at edge N -> out_pc = redirect_pc, out_valid = 1 after edge N. Zero-bubble redirect.
- While out_valid && !out_ready: out_instr, out_pc and out_misaligned are stable every cycle (a handshake requirement).
- Reset asserted mid-stream: out_valid drops immediately (asynchronous) and the in-flight word is lost. Restart follows the first-out_valid rule.

## Test plan
- Reset release with RESET_PC = 0 and mem[i] = 0x1000_0000 + i, out_ready = 1 -> out_valid rises 1 cycle after release; out_pc sequence 0, 4, 8, 12 with instr 0x1000_0000..0x1000_0003; fetch_count = 4 after 4 cycles.
- Stall: drop out_ready for 3 cycles while out_pc = 8 -> out_pc = 8 and instr 0x1000_0002 held for all 3 cycles; stall_count = 3; resume gives 12 next with no skip or duplicate.
- Redirect to 0x40 while streaming, including during a stall -> next out_pc = 0x40, instr 0x1000_0010, then 0x44; the discarded instruction is not counted in fetch_count.
- Wrap: redirect to 0x3FF8 -> out_pc 0x3FF8, 0x3FFC, 0x4000; imem_addr 0xFFE, 0xFFF, 0x000; instr mem[0xFFE], mem[0xFFF], mem[0].
- Misaligned redirect to 0x22 -> out_pc = 0x22, out_misaligned = 1, instr mem[8]; a later redirect to 0x30 clears the flag.
- Reset pulse mid-stream at out_pc = 0x14 -> out_valid = 0 and counters = 0 during reset; after release the stream restarts at RESET_PC.
